// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the CPU/VIDAC memory arbiter:
//   - FSM state encoding (CPU, VA = VIDAC address phase, VR = VIDAC return)
//   - default physical base of video memory
//   - 20-bit address-add helper that maps an 18-bit VIDAC offset into
//     the physical address space (modulo 2^20, wrap-around allowed)
package mem_arbiter_pkg;

    localparam logic [1:0] ST_CPU = 2'd0;
    localparam logic [1:0] ST_VA  = 2'd1;
    localparam logic [1:0] ST_VR  = 2'd2;

    typedef enum logic [1:0] {
        CPU = ST_CPU,
        VA  = ST_VA,
        VR  = ST_VR
    } arb_state_e;

    localparam logic [19:0] VID_BASE_DEFAULT = 20'hA0000;

    // Physical address of a VIDAC offset; carry out of bit 19 is dropped.
    function automatic logic [19:0] vid_phys_addr(input logic [19:0] base,
                                                  input logic [17:0] offset);
        return base + {2'b00, offset};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the three buses around the arbiter.
//   CPU side  : cpu_address, cpu_out, cpu_we -> arbiter; cpu_in, cpu_ce <- arbiter
//   VIDAC side: vid_req, vid_a, vid_o, vid_w -> arbiter; vid_ack, vid_i <- arbiter
//   Memory    : mem_address, mem_wdata, mem_we <- arbiter; mem_rdata -> arbiter
//   Modports: slave = the arbiter itself, master = the surrounding system.
interface mem_arbiter_if;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  cpu_in;
    logic        cpu_ce;

    logic        vid_req;
    logic [17:0] vid_a;
    logic [7:0]  vid_o;
    logic        vid_w;
    logic        vid_ack;
    logic [7:0]  vid_i;

    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_address, cpu_out, cpu_we,
        output cpu_in, cpu_ce,
        input  vid_req, vid_a, vid_o, vid_w,
        output vid_ack, vid_i,
        output mem_address, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_address, cpu_out, cpu_we,
        input  cpu_in, cpu_ce,
        output vid_req, vid_a, vid_o, vid_w,
        input  vid_ack, vid_i,
        input  mem_address, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single-port byte memory between the CPU (priority, stalled via
//   cpu_ce) and the VIDAC accelerator. While VIDAC requests, one two-cycle
//   slot (VA, VR) is stolen after every CPU_BURST CPU cycles.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   bus           - mem_arbiter_if.slave (CPU, VIDAC and memory buses)
//   stat_steal    - (MEM_ARB_STATS_EN only) VA entries since reset, saturating
//   stat_wait     - (MEM_ARB_STATS_EN only) cycles with vid_req=1 in CPU state
// Parameters:
//   VID_BASE      - physical base added to the VIDAC offset
//   CPU_BURST     - CPU cycles between VIDAC slots, 1..15
// Build option: define MEM_ARB_STATS_EN to add the two statistics counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [19:0] VID_BASE  = VID_BASE_DEFAULT,
    parameter int          CPU_BURST = 4
) (
    input  logic clock,
    input  logic reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] stat_steal,
    output logic [15:0] stat_wait
`endif
);

    localparam logic [4:0] BURST = 5'(CPU_BURST);

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       vid_ack_q, vid_ack_d;
    logic [7:0] vid_i_q, vid_i_d;
    logic [7:0] hold_q, hold_d;
    logic       last_cpu_q, last_cpu_d;

    logic [4:0] cnt_inc;
    logic       burst_done;

    assign cnt_inc    = {1'b0, cnt_q} + 5'd1;
    assign burst_done = (cnt_inc >= BURST);

    // Next state and memory-side muxing.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus.cpu_ce      = 1'b1;
        bus.mem_address = bus.cpu_address;
        bus.mem_wdata   = bus.cpu_out;
        bus.mem_we      = 1'b0;
        case (state_q)
            CPU: begin
                // reset forces state to CPU asynchronously; keep writes off then
                bus.mem_we = bus.cpu_we & ~reset;
                cnt_d      = burst_done ? BURST[3:0] : cnt_inc[3:0];
                if (bus.vid_req && burst_done)
                    state_d = VA;
            end
            VA: begin
                bus.cpu_ce      = 1'b0;
                bus.mem_address = vid_phys_addr(VID_BASE, bus.vid_a);
                bus.mem_wdata   = bus.vid_o;
                bus.mem_we      = bus.vid_w;
                cnt_d           = 4'd0;
                state_d         = VR;
            end
            VR: begin
                // CPU address goes back out now so its read data is ready
                // when cpu_ce returns.
                bus.cpu_ce = 1'b0;
                state_d    = CPU;
            end
            default: state_d = CPU;
        endcase
    end

    // VIDAC return path and CPU read-data hold.
    always_comb begin
        vid_ack_d  = (state_q == VR);
        vid_i_d    = (state_q == VR) ? bus.mem_rdata : vid_i_q;
        last_cpu_d = (state_q == CPU) || (state_q == VR);
        hold_d     = last_cpu_q ? bus.mem_rdata : hold_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= CPU;
            cnt_q      <= 4'd0;
            vid_ack_q  <= 1'b0;
            vid_i_q    <= 8'h00;
            hold_q     <= 8'h00;
            last_cpu_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vid_ack_q  <= vid_ack_d;
            vid_i_q    <= vid_i_d;
            hold_q     <= hold_d;
            last_cpu_q <= last_cpu_d;
        end
    end

    assign bus.vid_ack = vid_ack_q;
    assign bus.vid_i   = vid_i_q;
    // mem_rdata belongs to the CPU only when the previous cycle's address was
    // the CPU's; during the VIDAC return cycle the held byte is shown instead.
    assign bus.cpu_in  = last_cpu_q ? bus.mem_rdata : hold_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] steal_q, steal_d;
    logic [15:0] wait_q, wait_d;

    always_comb begin
        steal_d = steal_q;
        wait_d  = wait_q;
        if (state_q == CPU && state_d == VA && steal_q != 16'hFFFF)
            steal_d = steal_q + 16'd1;
        if (state_q == CPU && bus.vid_req && wait_q != 16'hFFFF)
            wait_d = wait_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            steal_q <= 16'd0;
            wait_q  <= 16'd0;
        end else begin
            steal_q <= steal_d;
            wait_q  <= wait_d;
        end
    end

    assign stat_steal = steal_q;
    assign stat_wait  = wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (CPU_BURST=4, VID_BASE=A0000) with a
//   1 MB byte memory model (registered read, one-cycle latency). Inputs are
//   driven 2 ns after the rising edge, outputs are checked after that.
//   With MEM_ARB_STATS_EN a second instance at CPU_BURST=1 exercises the
//   statistics counters.
module tb_mem_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_run  = 0;
    int n_fail = 0;

    mem_arbiter_if bus ();
    logic [7:0] mem [0:(1<<20)-1];

`ifdef MEM_ARB_STATS_EN
    logic [15:0] st_steal, st_wait;
    logic [15:0] st2_steal, st2_wait;
    logic        reset2;
    mem_arbiter_if bus2 ();
`endif

    mem_arbiter #(.VID_BASE(20'hA0000), .CPU_BURST(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_steal (st_steal),
        .stat_wait  (st_wait)
`endif
    );

`ifdef MEM_ARB_STATS_EN
    mem_arbiter #(.VID_BASE(20'hA0000), .CPU_BURST(1)) dut2 (
        .clock      (clock),
        .reset      (reset2),
        .bus        (bus2.slave),
        .stat_steal (st2_steal),
        .stat_wait  (st2_wait)
    );
`endif

    always @(posedge clock) begin
        if (bus.mem_we) mem[bus.mem_address] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << 20); i++) mem[i] = 8'h00;
        mem[20'hA0005] = 8'h3C;
        mem[20'hFFFF0] = 8'hEA;

        reset           = 1'b1;
        bus.cpu_address = 20'hFFFF0;
        bus.cpu_out     = 8'h11;
        bus.cpu_we      = 1'b1;
        bus.vid_req     = 1'b1;
        bus.vid_a       = 18'h00005;
        bus.vid_o       = 8'h00;
        bus.vid_w       = 1'b0;
`ifdef MEM_ARB_STATS_EN
        reset2           = 1'b1;
        bus2.cpu_address = 20'h00000;
        bus2.cpu_out     = 8'h00;
        bus2.cpu_we      = 1'b0;
        bus2.vid_req     = 1'b0;
        bus2.vid_a       = 18'h0;
        bus2.vid_o       = 8'h00;
        bus2.vid_w       = 1'b0;
        bus2.mem_rdata   = 8'h00;
`endif
        #1;
        // ---- reset state
        chk("rst_ce",    32'(bus.cpu_ce), 32'd1);
        chk("rst_addr",  32'(bus.mem_address), 32'hFFFF0);
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        chk("rst_ack",   32'(bus.vid_ack), 32'd0);
        chk("rst_vid_i", 32'(bus.vid_i), 32'h00);
        tick(); tick();
        chk("rst_cpu_in", 32'(bus.cpu_in), 32'hEA);
        chk("rst_mem_kept", 32'(mem[20'hFFFF0]), 32'hEA);

        // ---- VIDAC read + CPU read across stall (C0 = release cycle)
        reset      = 1'b0;
        bus.cpu_we = 1'b0;
        #1;
        chk("rd_ce_c0", 32'(bus.cpu_ce), 32'd1);
        tick(); chk("rd_ce_c1", 32'(bus.cpu_ce), 32'd1);
        tick(); chk("rd_ce_c2", 32'(bus.cpu_ce), 32'd1);
        tick(); chk("rd_ce_c3", 32'(bus.cpu_ce), 32'd1);
        tick(); // C4: VA
        chk("rd_ce_va",     32'(bus.cpu_ce), 32'd0);
        chk("rd_addr_va",   32'(bus.mem_address), 32'hA0005);
        chk("rd_we_va",     32'(bus.mem_we), 32'd0);
        chk("rd_cpu_in_va", 32'(bus.cpu_in), 32'hEA);
        chk("rd_ack_va",    32'(bus.vid_ack), 32'd0);
        tick(); // C5: VR
        chk("rd_ce_vr",     32'(bus.cpu_ce), 32'd0);
        chk("rd_addr_vr",   32'(bus.mem_address), 32'hFFFF0);
        chk("rd_cpu_in_vr", 32'(bus.cpu_in), 32'hEA);
        chk("rd_ack_vr",    32'(bus.vid_ack), 32'd0);
        tick(); // C6: CPU, ack pulse
        chk("rd_ce_c6",     32'(bus.cpu_ce), 32'd1);
        chk("rd_ack",       32'(bus.vid_ack), 32'd1);
        chk("rd_vid_i",     32'(bus.vid_i), 32'h3C);
        chk("rd_cpu_in_c6", 32'(bus.cpu_in), 32'hEA);
        bus.vid_req = 1'b0;
        tick(); // C7
        chk("rd_ack_gone",  32'(bus.vid_ack), 32'd0);
        chk("rd_vid_i_hold", 32'(bus.vid_i), 32'h3C);

        // ---- VIDAC write at wrap-edge offset, CPU write held off during stall
        bus.vid_a   = 18'h3FFFF;
        bus.vid_o   = 8'hAA;
        bus.vid_w   = 1'b1;
        bus.vid_req = 1'b1;
        #1;
        tick(); chk("wr_ce_c8", 32'(bus.cpu_ce), 32'd1);
        tick(); chk("wr_ce_c9", 32'(bus.cpu_ce), 32'd1);
        tick(); // C10: VA
        bus.cpu_address = 20'h00010;
        bus.cpu_out     = 8'h55;
        bus.cpu_we      = 1'b1;
        #1;
        chk("wr_ce_va",    32'(bus.cpu_ce), 32'd0);
        chk("wr_addr_va",  32'(bus.mem_address), 32'hDFFFF);
        chk("wr_we_va",    32'(bus.mem_we), 32'd1);
        chk("wr_data_va",  32'(bus.mem_wdata), 32'hAA);
        tick(); // C11: VR
        chk("wr_we_vr",    32'(bus.mem_we), 32'd0);
        chk("wr_addr_vr",  32'(bus.mem_address), 32'h00010);
        chk("wr_cpu_held_vr", 32'(mem[20'h00010]), 32'h00);
        tick(); // C12: CPU resumes, write presented
        chk("wr_ce_c12",   32'(bus.cpu_ce), 32'd1);
        chk("wr_we_c12",   32'(bus.mem_we), 32'd1);
        chk("wr_ack",      32'(bus.vid_ack), 32'd1);
        chk("wr_cpu_held_c12", 32'(mem[20'h00010]), 32'h00);
        bus.vid_req = 1'b0;
        tick(); // C13
        chk("wr_vid_mem",  32'(mem[20'hDFFFF]), 32'hAA);
        chk("wr_cpu_mem",  32'(mem[20'h00010]), 32'h55);
        chk("wr_other_mem", 32'(mem[20'hFFFF0]), 32'hEA);

        // ---- reset during VA
        bus.cpu_we      = 1'b0;
        bus.cpu_address = 20'hFFFF0;
        bus.vid_w       = 1'b0;
        bus.vid_a       = 18'h00005;
        bus.vid_req     = 1'b1;
        tick(); tick(); // C15
        chk("rv_ce_c15", 32'(bus.cpu_ce), 32'd1);
        tick(); // C16: VA
        chk("rv_ce_va", 32'(bus.cpu_ce), 32'd0);
        reset = 1'b1;
        #1;
        chk("rv_ce_rst",   32'(bus.cpu_ce), 32'd1);
        chk("rv_addr_rst", 32'(bus.mem_address), 32'hFFFF0);
        chk("rv_we_rst",   32'(bus.mem_we), 32'd0);
        tick(); // C17
        chk("rv_ack_rst", 32'(bus.vid_ack), 32'd0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rv_ce_burst%0d", k), 32'(bus.cpu_ce), 32'd1);
            chk($sformatf("rv_ack_burst%0d", k), 32'(bus.vid_ack), 32'd0);
            tick();
        end
        chk("rv_ce_va2", 32'(bus.cpu_ce), 32'd0);
        tick(); tick(); // ack cycle
        chk("rv_ack2",   32'(bus.vid_ack), 32'd1);
        chk("rv_vid_i2", 32'(bus.vid_i), 32'h3C);
        bus.vid_req = 1'b0;

        // ---- no request: CPU never stalls
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("idle_ce%0d", k), 32'(bus.cpu_ce), 32'd1);
        end

`ifdef MEM_ARB_STATS_EN
        // ---- statistics at CPU_BURST=1, request for three slots
        reset2       = 1'b0;
        bus2.vid_req = 1'b1;
        #1;
        chk("st_steal_0", 32'(st2_steal), 32'd0);
        chk("st_wait_0",  32'(st2_wait), 32'd0);
        for (int k = 0; k < 9; k++) tick(); // 3 x (CPU, VA, VR)
        chk("st_ack3", 32'(bus2.vid_ack), 32'd1);
        bus2.vid_req = 1'b0;
        tick();
        chk("st_steal", 32'(st2_steal), 32'd3);
        chk("st_wait",  32'(st2_wait), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
